// File: rtl/mem_stage.sv
// mem_stage: data-memory access and MEM/WB pipeline register.
// In: EX result, store data, control bits, stall/flush. Out: branch select, WB bundle, misalign pulse.
module mem_stage #(
  parameter int ADDR_W = 6
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        valid_ex,
  input  logic [31:0] brnch,
  input  logic        zero,
  input  logic [31:0] ALUresult,
  input  logic [31:0] rdData2,
  input  logic [4:0]  writeReg,
  input  logic        Branch,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic        RegWrite,
  input  logic        MemtoReg,
  input  logic        stall,
  input  logic        flush,
  output logic        PCSrc,
  output logic [31:0] brTarget,
  output logic        valid_wb,
  output logic [31:0] readData_wb,
  output logic [31:0] ALUresult_wb,
  output logic [4:0]  writeReg_wb,
  output logic        RegWrite_wb,
  output logic        MemtoReg_wb,
  output logic        misalign_err
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef struct packed {
    logic        valid;
    logic [31:0] rdata;
    logic [31:0] alu;
    logic [4:0]  wreg;
    logic        regwr;
    logic        m2r;
  } mem_wb_t;

  logic              live;
  logic              go;
  logic              aligned;
  logic [ADDR_W-1:0] addr;
  logic              ld_en;
  logic              st_en;
  logic [31:0]       rd_word;

  logic [31:0] mem_q [DEPTH];

  mem_wb_t wb_d;
  mem_wb_t wb_q;
  logic    mis_d;
  logic    mis_q;

  // Upper address bits are ignored; the array wraps.
  logic unused_addr_hi;
  assign unused_addr_hi = ^ALUresult[31:ADDR_W+2];

  assign live    = valid_ex & ~flush;
  assign go      = live & ~stall;
  assign aligned = (ALUresult[1:0] == 2'b00);
  assign addr    = ALUresult[ADDR_W+1:2];
  assign ld_en   = go & MemRead;
  assign st_en   = go & MemWrite & aligned;
  assign rd_word = mem_q[addr];

  // Stall does not mask the branch; flush does.
  assign PCSrc    = live & Branch & zero;
  assign brTarget = brnch;

  // No reset on the array; writes are gated off while in reset.
  always_ff @(posedge clk) begin
    if (rst_n && st_en) begin
      mem_q[addr] <= rdData2;
    end
  end

  always_comb begin
    wb_d = wb_q;
    if (!stall) begin
      wb_d.valid = live;
      wb_d.alu   = ALUresult;
      wb_d.wreg  = writeReg;
      wb_d.m2r   = MemtoReg;
      wb_d.regwr = live & RegWrite & ~(MemRead & ~aligned);
    end
    // Read-before-write: rd_word is the pre-edge contents.
    if (ld_en) begin
      wb_d.rdata = aligned ? rd_word : 32'h0;
    end
    mis_d = go & (MemRead | MemWrite) & ~aligned;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_q  <= '0;
      mis_q <= 1'b0;
    end else begin
      wb_q  <= wb_d;
      mis_q <= mis_d;
    end
  end

  assign valid_wb     = wb_q.valid;
  assign readData_wb  = wb_q.rdata;
  assign ALUresult_wb = wb_q.alu;
  assign writeReg_wb  = wb_q.wreg;
  assign RegWrite_wb  = wb_q.regwr;
  assign MemtoReg_wb  = wb_q.m2r;
  assign misalign_err = mis_q;

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed + randomized bench for mem_stage.
// A word-array reference model predicts every output each cycle.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid_ex;
  logic [31:0] brnch;
  logic        zero;
  logic [31:0] ALUresult;
  logic [31:0] rdData2;
  logic [4:0]  writeReg;
  logic        Branch, MemRead, MemWrite, RegWrite, MemtoReg;
  logic        stall, flush;
  logic        PCSrc;
  logic [31:0] brTarget;
  logic        valid_wb;
  logic [31:0] readData_wb;
  logic [31:0] ALUresult_wb;
  logic [4:0]  writeReg_wb;
  logic        RegWrite_wb, MemtoReg_wb, misalign_err;

  int ncmp = 0;
  int nerr = 0;

  mem_stage #(.ADDR_W(6)) dut (
    .clk(clk), .rst_n(rst_n), .valid_ex(valid_ex), .brnch(brnch),
    .zero(zero), .ALUresult(ALUresult), .rdData2(rdData2),
    .writeReg(writeReg), .Branch(Branch), .MemRead(MemRead),
    .MemWrite(MemWrite), .RegWrite(RegWrite), .MemtoReg(MemtoReg),
    .stall(stall), .flush(flush), .PCSrc(PCSrc), .brTarget(brTarget),
    .valid_wb(valid_wb), .readData_wb(readData_wb),
    .ALUresult_wb(ALUresult_wb), .writeReg_wb(writeReg_wb),
    .RegWrite_wb(RegWrite_wb), .MemtoReg_wb(MemtoReg_wb),
    .misalign_err(misalign_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] initv(input int i);
    return 32'h1357_0000 + i * 32'h0001_0203;
  endfunction

  // Reference model: a plain word array and the expected WB entry.
  logic [31:0] mm [64];
  logic        e_valid, e_rw, e_m2r, e_mis;
  logic [31:0] e_rd, e_alu;
  logic [4:0]  e_wr;

  logic     m_go, m_al;
  int       m_a;
  assign m_go = valid_ex && !flush && !stall;
  assign m_al = (ALUresult % 4) == 0;
  assign m_a  = int'((ALUresult / 4) % 64);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e_valid <= 0; e_rw <= 0; e_m2r <= 0; e_mis <= 0;
      e_rd <= 0; e_alu <= 0; e_wr <= 0;
    end else begin
      e_mis <= m_go && (MemRead || MemWrite) && !m_al;
      if (!stall) begin
        e_valid <= valid_ex && !flush;
        e_alu   <= ALUresult;
        e_wr    <= writeReg;
        e_m2r   <= MemtoReg;
        e_rw    <= valid_ex && !flush && RegWrite && !(MemRead && !m_al);
      end
      if (m_go && MemRead)
        e_rd <= m_al ? mm[m_a] : 32'h0;
      if (m_go && MemWrite && m_al)
        mm[m_a] <= rdData2;
    end
  end

  always @(negedge clk) begin
    chk("pcsrc", PCSrc, valid_ex && !flush && Branch && zero);
    chk("brtarget", brTarget, brnch);
    chk("valid_wb", valid_wb, e_valid);
    chk("readdata_wb", readData_wb, e_rd);
    chk("aluresult_wb", ALUresult_wb, e_alu);
    chk("writereg_wb", writeReg_wb, e_wr);
    chk("regwrite_wb", RegWrite_wb, e_rw);
    chk("memtoreg_wb", MemtoReg_wb, e_m2r);
    chk("misalign_err", misalign_err, e_mis);
  end

  task automatic step;
    @(posedge clk);
    #2;
  endtask

  task automatic set_idle;
    valid_ex = 0; brnch = 0; zero = 0; ALUresult = 0; rdData2 = 0;
    writeReg = 0; Branch = 0; MemRead = 0; MemWrite = 0;
    RegWrite = 0; MemtoReg = 0; stall = 0; flush = 0;
  endtask

  task automatic set_st(input logic [31:0] a, input logic [31:0] d);
    set_idle;
    valid_ex = 1; MemWrite = 1; ALUresult = a; rdData2 = d;
  endtask

  task automatic set_ld(input logic [31:0] a, input logic [4:0] r);
    set_idle;
    valid_ex = 1; MemRead = 1; RegWrite = 1; MemtoReg = 1;
    ALUresult = a; writeReg = r;
  endtask

  initial begin
    rst_n = 0;
    set_idle;
    repeat (3) step;
    rst_n = 1;
    for (int i = 0; i < 64; i++) begin
      set_st(i * 4, initv(i));
      step;
    end

    // Store then load.
    set_st(32'h10, 32'hDEAD_BEEF);
    step;
    set_ld(32'h10, 5'd7);
    step;
    chk("ld_data", readData_wb, 32'hDEAD_BEEF);
    chk("ld_regwr", RegWrite_wb, 1);
    chk("ld_wreg", writeReg_wb, 7);
    chk("ld_valid", valid_wb, 1);

    // Upper address bits wrap.
    set_ld(32'hFFFF_FF10, 5'd2);
    step;
    chk("wrap_data", readData_wb, 32'hDEAD_BEEF);

    // Branch.
    set_idle;
    valid_ex = 1; Branch = 1; zero = 1; brnch = 32'h40;
    #1;
    chk("br_take", PCSrc, 1);
    chk("br_tgt", brTarget, 32'h40);
    zero = 0;
    #1;
    chk("br_nz", PCSrc, 0);
    zero = 1; stall = 1;
    #1;
    chk("br_stall", PCSrc, 1);
    flush = 1;
    #1;
    chk("br_flush", PCSrc, 0);
    step;

    // Misaligned store and load.
    set_st(32'h13, 32'h1234_5678);
    step;
    chk("mis_pulse", misalign_err, 1);
    set_idle;
    step;
    chk("mis_clear", misalign_err, 0);
    set_ld(32'h10, 5'd1);
    step;
    chk("mis_keep", readData_wb, 32'hDEAD_BEEF);
    set_ld(32'h11, 5'd1);
    step;
    chk("misld_data", readData_wb, 0);
    chk("misld_regwr", RegWrite_wb, 0);
    chk("misld_err", misalign_err, 1);

    // Stall holding a store.
    set_idle;
    valid_ex = 1; RegWrite = 1; ALUresult = 32'h55; writeReg = 3;
    step;
    chk("pre_alu", ALUresult_wb, 32'h55);
    set_st(32'h20, 32'hCAFE_F00D);
    stall = 1;
    for (int k = 0; k < 3; k++) begin
      step;
      chk("stall_alu", ALUresult_wb, 32'h55);
      chk("stall_wreg", writeReg_wb, 3);
      chk("stall_rw", RegWrite_wb, 1);
    end
    stall = 0;
    step;
    chk("unstall_alu", ALUresult_wb, 32'h20);
    set_ld(32'h20, 5'd4);
    step;
    chk("stall_st", readData_wb, 32'hCAFE_F00D);

    // Flush squashes store, writeback and branch.
    set_st(32'h24, 32'h0000_0BAD);
    RegWrite = 1; Branch = 1; zero = 1; flush = 1;
    #1;
    chk("fl_pcsrc", PCSrc, 0);
    step;
    chk("fl_valid", valid_wb, 0);
    chk("fl_regwr", RegWrite_wb, 0);
    set_ld(32'h24, 5'd9);
    step;
    chk("fl_nowr", readData_wb, initv(9));

    // Asynchronous reset between edges.
    set_idle;
    valid_ex = 1; RegWrite = 1; MemtoReg = 1;
    ALUresult = 32'h77; writeReg = 5;
    step;
    chk("pre_rst", valid_wb, 1);
    #1 rst_n = 0;
    #1;
    chk("rst_valid", valid_wb, 0);
    chk("rst_rw", RegWrite_wb, 0);
    chk("rst_m2r", MemtoReg_wb, 0);
    chk("rst_rd", readData_wb, 0);
    chk("rst_alu", ALUresult_wb, 0);
    chk("rst_wreg", writeReg_wb, 0);
    set_idle;
    step;
    step;
    rst_n = 1;
    set_ld(32'h10, 5'd6);
    step;
    chk("rst_mem", readData_wb, 32'hDEAD_BEEF);

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      set_idle;
      valid_ex  = ($urandom_range(0, 9) < 8);
      Branch    = $urandom_range(0, 1);
      zero      = $urandom_range(0, 1);
      brnch     = $urandom;
      MemRead   = ($urandom_range(0, 99) < 35);
      MemWrite  = ($urandom_range(0, 99) < 35);
      RegWrite  = $urandom_range(0, 1);
      MemtoReg  = $urandom_range(0, 1);
      stall     = ($urandom_range(0, 4) == 0);
      flush     = ($urandom_range(0, 9) == 0);
      ALUresult = $urandom;
      if ($urandom_range(0, 3) != 0)
        ALUresult[1:0] = 2'b00;
      rdData2   = $urandom;
      writeReg  = 5'($urandom_range(0, 31));
      step;
    end

    set_idle;
    step;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
